core_mul_ctrl: RTL and testbench

CORE_MUL_CTRL -- requirements
Module: core_mul_ctrl

---
 rtl/core_pkg.sv | 26 ++
 rtl/core_mul_ctrl.sv | 166 ++++++++++++++++
 tb/tb_core_mul_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared core types: machine words, register numbers and the
//               multiply-controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  typedef logic [31:0] word;
  typedef logic [63:0] dword;
  typedef logic [3:0]  reg_num;

  typedef enum logic [2:0] {
    MC_IDLE  = 3'd0,
    MC_START = 3'd1,
    MC_WAIT  = 3'd2,
    MC_WB_LO = 3'd3,
    MC_WB_HI = 3'd4,
    MC_DRAIN = 3'd5
  } mul_ctrl_state;

endpackage

`default_nettype wire

// File: rtl/core_mul_ctrl.sv
// ============================================================================
// Module      : core_mul_ctrl
// Description : Sequences one multiply from issue, through an external
//               multiplier, to one or two register writebacks and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_mul_ctrl
  import core_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,

  input  logic   issue_valid,
  output logic   issue_ready,
  input  logic   op_long,
  input  logic   op_add,
  input  logic   op_sig,
  input  logic   op_setflags,
  input  reg_num rd_lo,
  input  reg_num rd_hi,
  input  word    op_a,
  input  word    op_b,
  input  word    op_c_hi,
  input  word    op_c_lo,
  input  logic   flush,

  output word    mul_a,
  output word    mul_b,
  output word    mul_c_hi,
  output word    mul_c_lo,
  output logic   mul_long,
  output logic   mul_add,
  output logic   mul_sig,
  output logic   mul_start,
  input  logic   mul_ready,
  input  word    mul_q_hi,
  input  word    mul_q_lo,

  output logic   wb_valid,
  input  logic   wb_ready,
  output reg_num wb_rd,
  output word    wb_value,

  output logic   flags_valid,
  output logic   flag_n,
  output logic   flag_z,

  output logic   busy
);

  mul_ctrl_state r_state;

  logic   r_long;
  logic   r_add;
  logic   r_sig;
  logic   r_setflags;
  reg_num r_rd_lo;
  reg_num r_rd_hi;
  word    r_a;
  word    r_b;
  word    r_c_hi;
  word    r_c_lo;
  dword   r_result;

  logic   w_wb_hi;
  logic   w_final_wb;
  logic   w_flag_n;
  logic   w_flag_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MC_IDLE;
      r_long     <= 1'b0;
      r_add      <= 1'b0;
      r_sig      <= 1'b0;
      r_setflags <= 1'b0;
      r_rd_lo    <= '0;
      r_rd_hi    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c_hi     <= '0;
      r_c_lo     <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        MC_IDLE: begin
          if (issue_valid) begin
            r_long     <= op_long;
            r_add      <= op_add;
            r_sig      <= op_sig;
            r_setflags <= op_setflags;
            r_rd_lo    <= rd_lo;
            r_rd_hi    <= rd_hi;
            r_a        <= op_a;
            r_b        <= op_b;
            r_c_hi     <= op_c_hi;
            r_c_lo     <= op_c_lo;
            r_state    <= MC_START;
          end
        end
        MC_START: begin
          r_state <= flush ? MC_DRAIN : MC_WAIT;
        end
        MC_WAIT: begin
          // A flush wins over a same-cycle result: the product is dropped.
          if (flush) begin
            r_state <= MC_DRAIN;
          end else if (mul_ready) begin
            r_result <= {mul_q_hi, mul_q_lo};
            r_state  <= MC_WB_LO;
          end
        end
        MC_WB_LO: begin
          if (wb_ready) begin
            r_state <= r_long ? MC_WB_HI : MC_IDLE;
          end
        end
        MC_WB_HI: begin
          if (wb_ready) begin
            r_state <= MC_IDLE;
          end
        end
        MC_DRAIN: begin
          if (mul_ready) begin
            r_state <= MC_IDLE;
          end
        end
        default: begin
          r_state <= MC_IDLE;
        end
      endcase
    end
  end

  assign issue_ready = (r_state == MC_IDLE);
  assign busy        = (r_state != MC_IDLE);
  assign mul_start   = (r_state == MC_START);

  assign mul_a    = r_a;
  assign mul_b    = r_b;
  assign mul_c_hi = r_c_hi;
  assign mul_c_lo = r_c_lo;
  assign mul_long = r_long;
  assign mul_add  = r_add;
  assign mul_sig  = r_sig;

  assign w_wb_hi    = (r_state == MC_WB_HI);
  assign wb_valid   = (r_state == MC_WB_LO) || w_wb_hi;
  assign w_final_wb = w_wb_hi || ((r_state == MC_WB_LO) && !r_long);

  // Data outputs read as zero whenever their strobe is low.
  assign wb_rd    = !wb_valid ? '0 : (w_wb_hi ? r_rd_hi : r_rd_lo);
  assign wb_value = !wb_valid ? '0 : (w_wb_hi ? r_result[63:32] : r_result[31:0]);

  assign w_flag_n = r_long ? r_result[63] : r_result[31];
  assign w_flag_z = r_long ? (r_result == '0) : (r_result[31:0] == '0);

  assign flags_valid = w_final_wb && wb_ready && r_setflags;
  assign flag_n      = flags_valid && w_flag_n;
  assign flag_z      = flags_valid && w_flag_z;

endmodule

`default_nettype wire

// File: tb/tb_core_mul_ctrl.sv
// ============================================================================
// Module      : tb_core_mul_ctrl
// Description : Self-checking bench for core_mul_ctrl with a behavioural
//               multiplier and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_mul_ctrl;
  import core_pkg::*;

  typedef struct {
    logic [31:0] a, b, chi, clo;
    bit          lng, add, sig, setf;
    logic [3:0]  lo, hi;
  } op_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   issue_valid, issue_ready;
  logic   op_long, op_add, op_sig, op_setflags;
  reg_num rd_lo, rd_hi;
  word    op_a, op_b, op_c_hi, op_c_lo;
  logic   flush;
  word    mul_a, mul_b, mul_c_hi, mul_c_lo;
  logic   mul_long, mul_add, mul_sig, mul_start, mul_ready;
  word    mul_q_hi, mul_q_lo;
  logic   wb_valid, wb_ready;
  reg_num wb_rd;
  word    wb_value;
  logic   flags_valid, flag_n, flag_z, busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] dut_rf [16];

  always #5 clk = ~clk;

  core_mul_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op_long(op_long), .op_add(op_add), .op_sig(op_sig), .op_setflags(op_setflags),
    .rd_lo(rd_lo), .rd_hi(rd_hi),
    .op_a(op_a), .op_b(op_b), .op_c_hi(op_c_hi), .op_c_lo(op_c_lo),
    .flush(flush),
    .mul_a(mul_a), .mul_b(mul_b), .mul_c_hi(mul_c_hi), .mul_c_lo(mul_c_lo),
    .mul_long(mul_long), .mul_add(mul_add), .mul_sig(mul_sig), .mul_start(mul_start),
    .mul_ready(mul_ready), .mul_q_hi(mul_q_hi), .mul_q_lo(mul_q_lo),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_value(wb_value),
    .flags_valid(flags_valid), .flag_n(flag_n), .flag_z(flag_z),
    .busy(busy)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, b, chi, clo,
                                          input bit lng, add, sig);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    if (sig) begin
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    if (add) p = p + (lng ? {chi, clo} : {32'd0, clo});
    return p;
  endfunction

  // Level-style multiplier: ready while idle, busy for mul_lat cycles after a start.
  int          mul_lat = 4;
  int          mul_cnt;
  logic [63:0] mul_prod;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_cnt  <= 0;
      mul_prod <= '0;
    end else if (mul_start) begin
      mul_cnt  <= mul_lat - 1;
      mul_prod <= ref_mul(mul_a, mul_b, mul_c_hi, mul_c_lo, mul_long, mul_add, mul_sig);
    end else if (mul_cnt > 0) begin
      mul_cnt <= mul_cnt - 1;
    end
  end
  assign mul_ready = (mul_cnt == 0);
  assign {mul_q_hi, mul_q_lo} = mul_ready ? mul_prod : 64'hBADC_0FFE_E0DD_F00D;

  function automatic op_t mk(input logic [31:0] a, b, chi, clo,
                             input bit lng, add, sig, setf, input logic [3:0] lo, hi);
    op_t o;
    o.a = a; o.b = b; o.chi = chi; o.clo = clo;
    o.lng = lng; o.add = add; o.sig = sig; o.setf = setf;
    o.lo = lo; o.hi = hi;
    return o;
  endfunction

  task automatic issue_op(input op_t o);
    int k = 0;
    @(negedge clk);
    op_a = o.a; op_b = o.b; op_c_hi = o.chi; op_c_lo = o.clo;
    op_long = o.lng; op_add = o.add; op_sig = o.sig; op_setflags = o.setf;
    rd_lo = o.lo; rd_hi = o.hi;
    issue_valid = 1'b1;
    #1;
    while (!issue_ready && k < 50) begin
      @(negedge clk); #1; k++;
    end
    n_tests++;
    if (!issue_ready) begin
      n_fail++;
      $display("FAIL issue_timeout: issue_ready=%b required 1", issue_ready);
    end
    @(posedge clk); #1;
    issue_valid = 1'b0;
    // Scramble inputs so any use of unlatched operands shows up.
    op_a = $urandom; op_b = $urandom; op_c_hi = $urandom; op_c_lo = $urandom;
    op_long = 1'($urandom); op_add = 1'($urandom); op_sig = 1'($urandom);
    op_setflags = 1'($urandom); rd_lo = 4'($urandom); rd_hi = 4'($urandom);
  endtask

  task automatic run_op(input op_t o, input int lat, input int stall_pct, input string name);
    logic [63:0] p;
    logic [3:0]  wrd [$];
    logic [31:0] wval[$];
    logic [3:0]  erd [2];
    logic [31:0] eval[2];
    int nf = 0, ns = 0, k = 0, nexp;
    bit fn = 0, fz = 0, cmd_ok = 1;
    p = ref_mul(o.a, o.b, o.chi, o.clo, o.lng, o.add, o.sig);
    erd[0] = o.lo;  eval[0] = p[31:0];
    erd[1] = o.hi;  eval[1] = p[63:32];
    nexp = o.lng ? 2 : 1;
    mul_lat = lat;
    issue_op(o);
    do begin
      @(negedge clk);
      wb_ready = ($urandom_range(0, 99) >= stall_pct);
      #1; k++;
      if (mul_start) begin
        ns++;
        cmd_ok = (mul_a === o.a) && (mul_b === o.b) && (mul_c_hi === o.chi) &&
                 (mul_c_lo === o.clo) && (mul_long === o.lng) &&
                 (mul_add === o.add) && (mul_sig === o.sig);
      end
      if (wb_valid && wb_ready) begin
        wrd.push_back(wb_rd);
        wval.push_back(wb_value);
        dut_rf[wb_rd] = wb_value;
      end
      if (flags_valid) begin
        nf++; fn = flag_n; fz = flag_z;
      end
    end while (!issue_ready && k < 300);
    wb_ready = 1'b1;

    n_tests++;
    if (k >= 300) begin
      n_fail++; $display("FAIL %s_done: cycles=%0d required <300", name, k);
    end
    n_tests++;
    if (ns !== 1 || !cmd_ok) begin
      n_fail++; $display("FAIL %s_cmd: starts=%0d cmd_ok=%b required 1/1", name, ns, cmd_ok);
    end
    n_tests++;
    if (wrd.size() !== nexp) begin
      n_fail++; $display("FAIL %s_nwrites: got %0d required %0d", name, wrd.size(), nexp);
    end else begin
      for (int i = 0; i < nexp; i++) begin
        n_tests++;
        if (wrd[i] !== erd[i] || wval[i] !== eval[i]) begin
          n_fail++;
          $display("FAIL %s_write%0d: got r%0d=%h required r%0d=%h",
                   name, i, wrd[i], wval[i], erd[i], eval[i]);
        end
      end
    end
    n_tests++;
    if (nf !== (o.setf ? 1 : 0)) begin
      n_fail++; $display("FAIL %s_nflags: got %0d required %0d", name, nf, o.setf ? 1 : 0);
    end else if (o.setf) begin
      n_tests++;
      if (fn !== (o.lng ? p[63] : p[31]) ||
          fz !== (o.lng ? (p == 64'd0) : (p[31:0] == 32'd0))) begin
        n_fail++;
        $display("FAIL %s_flags: got N=%b Z=%b required N=%b Z=%b", name, fn, fz,
                 o.lng ? p[63] : p[31], o.lng ? (p == 64'd0) : (p[31:0] == 32'd0));
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_tests++;
    if ({issue_ready, busy, mul_start, wb_valid, flags_valid} !== 5'b10000) begin
      n_fail++;
      $display("FAIL %s_ctrl: got %b required 10000", name,
               {issue_ready, busy, mul_start, wb_valid, flags_valid});
    end
    n_tests++;
    if ((mul_a | mul_b | mul_c_hi | mul_c_lo | wb_value) !== 32'd0 ||
        {wb_rd, mul_long, mul_add, mul_sig, flag_n, flag_z} !== 9'd0) begin
      n_fail++;
      $display("FAIL %s_data: got a=%h b=%h rd=%h val=%h required all zero",
               name, mul_a, mul_b, wb_rd, wb_value);
    end
  endtask

  task automatic test_reset();
    #1;
    check_idle_outputs("reset");
  endtask

  task automatic test_latency();
    int k, start_k = -1, wb_k = -1;
    mul_lat = 4;
    issue_op(mk(32'd3, 32'd3, 0, 0, 0, 0, 0, 0, 4'd9, 4'd0));
    for (k = 1; k <= 12; k++) begin
      @(negedge clk); wb_ready = 1'b1; #1;
      if (mul_start && start_k < 0) start_k = k;
      if (wb_valid && wb_k < 0) wb_k = k;
    end
    n_tests++;
    if (start_k !== 1 || wb_k !== 6) begin
      n_fail++;
      $display("FAIL latency: got start=+%0d wb=+%0d required +1/+6", start_k, wb_k);
    end
  endtask

  task automatic test_stall();
    logic [63:0] p;
    int k = 0;
    p = ref_mul(32'h1234_5678, 32'd9, 0, 0, 1, 0, 0);
    mul_lat = 3;
    wb_ready = 1'b0;
    issue_op(mk(32'h1234_5678, 32'd9, 0, 0, 1, 0, 0, 0, 4'd5, 4'd6));
    do begin
      @(negedge clk); #1; k++;
    end while (!wb_valid && k < 30);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      flush = 1'b1;
      n_tests++;
      if ({wb_valid, issue_ready, wb_rd, wb_value} !== {1'b1, 1'b0, 4'd5, p[31:0]}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got v=%b ir=%b r%0d=%h required v=1 ir=0 r5=%h",
                 i, wb_valid, issue_ready, wb_rd, wb_value, p[31:0]);
      end
    end
    @(negedge clk); flush = 1'b1; wb_ready = 1'b1; #1;
    n_tests++;
    if ({wb_valid, wb_rd, wb_value} !== {1'b1, 4'd5, p[31:0]}) begin
      n_fail++;
      $display("FAIL stall_lo: got v=%b r%0d=%h required r5=%h", wb_valid, wb_rd, wb_value, p[31:0]);
    end
    @(negedge clk); #1;
    n_tests++;
    if ({wb_valid, wb_rd, wb_value} !== {1'b1, 4'd6, p[63:32]}) begin
      n_fail++;
      $display("FAIL stall_hi: got v=%b r%0d=%h required r6=%h", wb_valid, wb_rd, wb_value, p[63:32]);
    end
    @(negedge clk); flush = 1'b0; #1;
    n_tests++;
    if (issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_idle: issue_ready=%b required 1", issue_ready);
    end
  endtask

  task automatic test_flush();
    int fk [3] = '{1, 3, 5};
    for (int t = 0; t < 3; t++) begin
      int nwb = 0, nf = 0, idle_k = -1, exp_k;
      mul_lat = 4;
      exp_k = ((fk[t] + 1) > (1 + mul_lat) ? (fk[t] + 1) : (1 + mul_lat)) + 1;
      issue_op(mk($urandom, $urandom, 0, 0, 0, 0, 0, 1, 4'd7, 4'd0));
      for (int k = 1; k <= 20 && idle_k < 0; k++) begin
        @(negedge clk); flush = (k == fk[t]); wb_ready = 1'b1; #1;
        if (wb_valid) nwb++;
        if (flags_valid) nf++;
        if (issue_ready) idle_k = k;
      end
      flush = 1'b0;
      n_tests++;
      if (nwb !== 0 || nf !== 0 || idle_k !== exp_k) begin
        n_fail++;
        $display("FAIL flush_at%0d: got wb=%0d flags=%0d idle=+%0d required 0/0/+%0d",
                 fk[t], nwb, nf, idle_k, exp_k);
      end
      run_op(mk(32'd2, 32'd2, 0, 0, 0, 0, 0, 0, 4'd8, 4'd0), 4, 0, "after_flush");
    end
  endtask

  task automatic test_reset_mid();
    mul_lat = 5;
    issue_op(mk(32'd11, 32'd13, 0, 0, 1, 0, 0, 1, 4'd10, 4'd11));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_mid");
    @(negedge clk); rst_n = 1'b1; #1;
    n_tests++;
    if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got v=%b ir=%b required 0/1", wb_valid, issue_ready);
    end
    run_op(mk(32'd5, 32'd5, 0, 0, 0, 0, 0, 0, 4'd12, 4'd0), 4, 0, "after_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      op_t o;
      o = mk($urandom, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
      if (i % 5 == 0) o.b = 32'd0;
      run_op(o, $urandom_range(1, 6), $urandom_range(0, 50), "random");
    end
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    op_long = 0; op_add = 0; op_sig = 0; op_setflags = 0;
    rd_lo = 0; rd_hi = 0; op_a = 0; op_b = 0; op_c_hi = 0; op_c_lo = 0;
    for (int i = 0; i < 16; i++) dut_rf[i] = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    @(negedge clk); rst_n = 1'b1;

    run_op(mk(32'd7, 32'd6, 0, 0, 0, 0, 0, 1, 4'd3, 4'd0), 4, 0, "short_mul");
    n_tests++;
    if (dut_rf[3] !== 32'd42) begin
      n_fail++; $display("FAIL short_mul_r3: got %h required 0000002a", dut_rf[3]);
    end
    run_op(mk(32'hFFFF_FFFE, 32'd3, 32'd0, 32'h10, 1, 1, 1, 0, 4'd1, 4'd2), 4, 0, "smlal");
    test_latency();
    test_stall();
    test_flush();
    test_reset_mid();
    run_op(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 0, 0, 1, 4'd4, 4'd4), 3, 30, "umull");
    n_tests++;
    if (dut_rf[4] !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL umull_r4: got %h required fffffffe", dut_rf[4]);
    end
    run_op(mk(32'd0, 32'd5, 0, 0, 0, 0, 0, 1, 4'd1, 4'd0), 2, 0, "zero_short");
    run_op(mk(32'h1_0000, 32'h1_0000, 0, 0, 0, 0, 0, 1, 4'd2, 4'd0), 2, 0, "lo_zero_short");
    run_op(mk(32'h1_0000, 32'h1_0000, 0, 0, 1, 0, 0, 1, 4'd2, 4'd3), 2, 0, "lo_zero_long");
    run_op(mk(32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 1, 1, 4'd6, 4'd0), 1, 0, "neg_short");
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
